// File: rtl/noc_flit_arbiter.sv
// Round-robin flit arbiter: locks one requester per packet
// and forwards its flits to the NSU with one cycle of latency.
module noc_flit_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int REQ_NUM    = 4,
    parameter int GID_W      = 2
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_flit,
    input  logic [REQ_NUM-1:0]            req_valid,
    input  logic [REQ_NUM-1:0]            req_head,
    input  logic [REQ_NUM-1:0]            req_tail,
    output logic [REQ_NUM-1:0]            req_ready,
    output logic [DATA_WIDTH:0]           noc2axi_data,
    output logic                          s_is_head,
    output logic                          s_is_tail,
    input  logic                          nsu_busy,
    output logic [GID_W-1:0]              grant_id,
    output logic [15:0]                   pkt_cnt,
    output logic                          proto_err
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e                  state_q, state_d;
    logic [GID_W-1:0]        ptr_q, ptr_d;
    logic [GID_W-1:0]        gnt_q, gnt_d;
    logic                    first_q, first_d;
    logic [DATA_WIDTH:0]     data_q, data_d;
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   flit_arr [REQ_NUM];
    logic [GID_W-1:0]        cand;
    logic                    found;

    // Split the packed flit bus into per-requester words
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            flit_arr[i] = req_flit[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Arbitration, lock handling and output staging
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        data_d    = '0;
        head_d    = 1'b0;
        tail_d    = 1'b0;
        req_ready = '0;
        found     = 1'b0;
        cand      = '0;
        unique case (state_q)
            IDLE: begin
                // Stray body/tail flits are drained so they cannot stall
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (req_valid[i] && !req_head[i]) begin
                        req_ready[i] = 1'b1;
                        err_d        = 1'b1;
                    end
                end
                for (int k = 0; k < REQ_NUM; k++) begin
                    cand = GID_W'((int'(ptr_q) + k) % REQ_NUM);
                    if (!found && req_valid[cand] && req_head[cand]) begin
                        found = 1'b1;
                        gnt_d = cand;
                    end
                end
                if (found) begin
                    state_d = LOCK;
                    first_d = 1'b1;
                end
            end
            LOCK: begin
                req_ready[gnt_q] = !nsu_busy;
                if (req_valid[gnt_q] && !nsu_busy) begin
                    data_d  = {1'b1, flit_arr[gnt_q]};
                    head_d  = req_head[gnt_q];
                    tail_d  = req_tail[gnt_q];
                    first_d = 1'b0;
                    // Head must appear exactly on the first flit
                    if (first_q != req_head[gnt_q]) begin
                        err_d = 1'b1;
                    end
                    if (req_tail[gnt_q]) begin
                        state_d = IDLE;
                        ptr_d   = GID_W'((int'(gnt_q) + 1) % REQ_NUM);
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
        endcase
        if (noc_rst) begin
            req_ready = '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            first_q <= first_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign noc2axi_data = data_q;
    assign s_is_head    = head_q;
    assign s_is_tail    = tail_q;
    assign grant_id     = gnt_q;
    assign pkt_cnt      = cnt_q;
    assign proto_err    = err_q;

endmodule
